// File: rtl/seg_display_arbiter_if.sv
// Message-source handshake into the display arbiter: level request, four digits,
// and the accept pulse / busy status returned by the arbiter.
interface seg_display_arbiter_if;
   logic       msg_req;
   logic [3:0] msg_d0;
   logic [3:0] msg_d1;
   logic [3:0] msg_d2;
   logic [3:0] msg_d3;
   logic       msg_ack;
   logic       busy;

   modport master (
      output msg_req, msg_d0, msg_d1, msg_d2, msg_d3,
      input  msg_ack, busy
   );

   modport slave (
      input  msg_req, msg_d0, msg_d1, msg_d2, msg_d3,
      output msg_ack, busy
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Shares the 4-digit display between the time readout and one-shot messages:
// each message is held for HOLD_CYCLES, followed by GAP_CYCLES of forced time readout.
module seg_display_arbiter #(
   parameter int         HOLD_CYCLES = 100_000_000,
   parameter int         GAP_CYCLES  = 50_000_000,
   parameter int         BLINK_HALF  = 25_000_000,
   parameter logic [3:0] BLANK_CODE  = 4'hF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [3:0]                  time_d0,
   input  logic [3:0]                  time_d1,
   input  logic [3:0]                  time_d2,
   input  logic [3:0]                  time_d3,
   input  logic                        blink_en,
   seg_display_arbiter_if.slave        msg,
   output logic [3:0]                  bin0,
   output logic [3:0]                  bin1,
   output logic [3:0]                  bin2,
   output logic [3:0]                  bin3
);

   localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ?
                            ((HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF) :
                            ((GAP_CYCLES  > BLINK_HALF) ? GAP_CYCLES  : BLINK_HALF);
   localparam int CW = $clog2(MAX_CNT) + 1;

   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] BLINK_LD = CW'(BLINK_HALF - 1);

   typedef enum logic [1:0] {S_TIME, S_MSG, S_GAP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] hcnt, hcnt_nxt;
   logic [CW-1:0] bcnt;
   logic          phase;
   logic          accept;
   logic [3:0]    m0, m1, m2, m3;
   logic [3:0]    d0, d1, d2, d3;
   logic          ack_r, busy_r;

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      accept    = 1'b0;
      case (state)
         S_TIME: begin
            if (msg.msg_req) begin
               state_nxt = S_MSG;
               hcnt_nxt  = HOLD_LD;
               accept    = 1'b1;
            end
         end
         S_MSG: begin
            if (hcnt == '0) begin
               state_nxt = S_GAP;
               hcnt_nxt  = GAP_LD;
            end else begin
               hcnt_nxt = hcnt - CW'(1);
            end
         end
         S_GAP: begin
            if (hcnt == '0) state_nxt = S_TIME;
            else            hcnt_nxt  = hcnt - CW'(1);
         end
         default: begin
            state_nxt = S_TIME;
            hcnt_nxt  = '0;
         end
      endcase

      // Digit source follows the state being entered, so the accept edge already shows the message
      if (accept) begin
         d0 = msg.msg_d0; d1 = msg.msg_d1; d2 = msg.msg_d2; d3 = msg.msg_d3;
      end else if (state_nxt == S_MSG) begin
         d0 = m0; d1 = m1; d2 = m2; d3 = m3;
      end else if (phase) begin
         d0 = time_d0; d1 = time_d1; d2 = time_d2; d3 = time_d3;
      end else begin
         d0 = BLANK_CODE; d1 = BLANK_CODE; d2 = BLANK_CODE; d3 = BLANK_CODE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_TIME;
         hcnt   <= '0;
         bcnt   <= '0;
         phase  <= 1'b1;
         m0     <= 4'h0; m1 <= 4'h0; m2 <= 4'h0; m3 <= 4'h0;
         bin0   <= 4'h0; bin1 <= 4'h0; bin2 <= 4'h0; bin3 <= 4'h0;
         ack_r  <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         hcnt   <= hcnt_nxt;
         ack_r  <= accept;
         busy_r <= (state_nxt == S_MSG);
         bin0   <= d0; bin1 <= d1; bin2 <= d2; bin3 <= d3;
         if (accept) begin
            m0 <= msg.msg_d0; m1 <= msg.msg_d1; m2 <= msg.msg_d2; m3 <= msg.msg_d3;
         end
         // Blink counter runs regardless of state; only the digit mux ignores it in MSG
         if (!blink_en) begin
            bcnt  <= '0;
            phase <= 1'b1;
         end else if (bcnt == BLINK_LD) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt  <= bcnt + CW'(1);
         end
      end
   end

   assign msg.msg_ack = ack_r;
   assign msg.busy    = busy_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a timeline-based reference model
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_seg_display_arbiter;
   localparam int HOLD  = 4;
   localparam int GAP   = 2;
   localparam int BLINK = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] time_d0 = 4'h0, time_d1 = 4'h0, time_d2 = 4'h0, time_d3 = 4'h0;
   logic       blink_en = 1'b0;
   logic [3:0] bin0, bin1, bin2, bin3;

   int ntest = 0;
   int nfail = 0;

   seg_display_arbiter_if mif ();

   seg_display_arbiter #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .BLINK_HALF  (BLINK),
      .BLANK_CODE  (4'hF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .time_d0  (time_d0),
      .time_d1  (time_d1),
      .time_d2  (time_d2),
      .time_d3  (time_d3),
      .blink_en (blink_en),
      .msg      (mif.slave),
      .bin0     (bin0),
      .bin1     (bin1),
      .bin2     (bin2),
      .bin3     (bin3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a message accepted at edge ka owns the display for edges
   // ka..ka+HOLD-1, and the next accept is allowed from ka+HOLD+GAP+1 onward.
   // Blink phase after n consecutive enabled edges is on iff floor(n/BLINK) is even.
   int         t    = 0;
   int         ka   = -1000;
   int         brun = 0;
   bit         ph   = 1'b1;
   logic [3:0] mm [4];
   logic [3:0] eb [4];
   logic       ea = 1'b0;
   logic       ebusy = 1'b0;

   always @(posedge clk) begin
      logic acc;
      logic show;
      t = t + 1;
      if (rst) begin
         ka = -1000;
         brun = 0;
         ph = 1'b1;
         for (int i = 0; i < 4; i++) eb[i] = 4'h0;
         ea = 1'b0;
         ebusy = 1'b0;
      end else begin
         acc = mif.msg_req && (t >= ka + HOLD + GAP + 1);
         if (acc) begin
            ka = t;
            mm[0] = mif.msg_d0; mm[1] = mif.msg_d1; mm[2] = mif.msg_d2; mm[3] = mif.msg_d3;
         end
         show = (t - ka) < HOLD;
         if (show) begin
            for (int i = 0; i < 4; i++) eb[i] = mm[i];
         end else if (ph) begin
            eb[0] = time_d0; eb[1] = time_d1; eb[2] = time_d2; eb[3] = time_d3;
         end else begin
            for (int i = 0; i < 4; i++) eb[i] = 4'hF;
         end
         ea = acc;
         ebusy = show;
         brun = blink_en ? brun + 1 : 0;
         ph = ((brun / BLINK) % 2) == 0;
      end
      #1;
      chk("model_bin0", bin0, eb[0]);
      chk("model_bin1", bin1, eb[1]);
      chk("model_bin2", bin2, eb[2]);
      chk("model_bin3", bin3, eb[3]);
      chk("model_ack", 4'(mif.msg_ack), 4'(ea));
      chk("model_busy", 4'(mif.busy), 4'(ebusy));
   end

   task automatic set_msg(input logic req, input logic [3:0] a, b, c, d);
      mif.msg_req = req;
      mif.msg_d0 = a; mif.msg_d1 = b; mif.msg_d2 = c; mif.msg_d3 = d;
   endtask

   initial begin
      set_msg(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

      // 1: reset and pass-through
      repeat (2) @(negedge clk);
      chk("rst_bin0", bin0, 4'h0);
      chk("rst_bin3", bin3, 4'h0);
      chk("rst_ack", 4'(mif.msg_ack), 4'h0);
      chk("rst_busy", 4'(mif.busy), 4'h0);
      rst = 1'b0;
      time_d0 = 4'h1; time_d1 = 4'h2; time_d2 = 4'h3; time_d3 = 4'h4;
      @(negedge clk);
      chk("pass_bin0", bin0, 4'h1);
      chk("pass_bin1", bin1, 4'h2);
      chk("pass_bin2", bin2, 4'h3);
      chk("pass_bin3", bin3, 4'h4);

      // 2: single message
      set_msg(1'b1, 4'hA, 4'hB, 4'hC, 4'hD);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("msg_bin1", bin1, 4'hB);
            chk("msg_bin3", bin3, 4'hD);
            mif.msg_req = 1'b0;
         end
         chk("msg_ack", 4'(mif.msg_ack), (i == 0) ? 4'h1 : 4'h0);
         chk("msg_busy", 4'(mif.busy), (i < 4) ? 4'h1 : 4'h0);
         chk("msg_bin0", bin0, (i < 4) ? 4'hA : 4'h1);
      end

      // 3: back-to-back requests
      set_msg(1'b1, 4'h5, 4'h6, 4'h7, 4'h8);
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         chk("b2b_ack", 4'(mif.msg_ack), ((i % 7) == 0) ? 4'h1 : 4'h0);
         chk("b2b_bin0", bin0, ((i % 7) < 4) ? 4'h5 : 4'h1);
         if (i == 20) mif.msg_req = 1'b0;
      end

      // 4: blink, message during blank phase, blink release
      blink_en = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i <= 14) chk("blink_bin0", bin0, (((i / 3) % 2) == 1) ? 4'hF : 4'h1);
         if (i >= 15 && i <= 18) begin
            chk("blinkmsg_bin0", bin0, 4'h9);
            chk("blinkmsg_bin1", bin1, 4'hA);
            chk("blinkmsg_bin2", bin2, 4'hB);
            chk("blinkmsg_bin3", bin3, 4'hC);
         end
         if (i == 14) set_msg(1'b1, 4'h9, 4'hA, 4'hB, 4'hC);
         if (i == 15) begin
            chk("blinkmsg_ack", 4'(mif.msg_ack), 4'h1);
            mif.msg_req = 1'b0;
         end
         if (i == 21) blink_en = 1'b0;
         if (i == 23) begin
            chk("unblink_bin0", bin0, 4'h1);
            chk("unblink_bin3", bin3, 4'h4);
         end
      end

      // 5: reset on the second MSG cycle, pending request re-accepted
      set_msg(1'b1, 4'h3, 4'h3, 4'h3, 4'h3);
      @(negedge clk);
      chk("midrst_first_ack", 4'(mif.msg_ack), 4'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_bin0", bin0, 4'h0);
      chk("midrst_busy", 4'(mif.busy), 4'h0);
      chk("midrst_ack", 4'(mif.msg_ack), 4'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("reacc_ack", 4'(mif.msg_ack), 4'h1);
      chk("reacc_busy", 4'(mif.busy), 4'h1);
      chk("reacc_bin0", bin0, 4'h3);

      // 6: request and reset on the same edge
      rst = 1'b1;
      @(negedge clk);
      chk("simul_ack", 4'(mif.msg_ack), 4'h0);
      chk("simul_bin0", bin0, 4'h0);
      chk("simul_busy", 4'(mif.busy), 4'h0);
      rst = 1'b0;
      mif.msg_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
